dbg_cmd_sysclk_decoder: RTL and testbench

Parametrised system-clock side of the CPU debug slave. It takes quasi-static scan data (`sr`) and instruction (`ir_in`) from the JTAG TCK domain, together with toggle-encoded update-DR and update-IR events. It resynchronises those events onto `clk`, queues each captured command in a small FIFO, and on consumption emits one-cycle `take_action` / `take_no_action` strobes per instruction channel. It generalises the fixed 38-bit / 2-bit-IR decoder: data width, IR width, sync depth and queue depth are parameters, and back-pressure and overflow reporting are new.

---
 rtl/dbg_cmd_sysclk_decoder_pkg.sv | 19 +
 rtl/dbg_cmd_sysclk_decoder_toggle_sync.sv | 27 ++
 rtl/dbg_cmd_sysclk_decoder.sv | 129 ++++++++++++
 tb/tb_dbg_cmd_sysclk_decoder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_cmd_sysclk_decoder_pkg.sv
// Shared widths, instruction codes and the queued command layout for the
// system-clock side of the CPU debug slave.
package dbg_cmd_pkg;

  localparam int DBG_DATA_W  = 38;
  localparam int DBG_IR_W    = 2;
  localparam int DBG_ACT_BIT = 34;

  localparam logic [DBG_IR_W-1:0] IR_OCIMEM    = 2'd0;
  localparam logic [DBG_IR_W-1:0] IR_TRACE     = 2'd1;
  localparam logic [DBG_IR_W-1:0] IR_BREAK     = 2'd2;
  localparam logic [DBG_IR_W-1:0] IR_TRACECTRL = 2'd3;

  typedef struct packed {
    logic [DBG_IR_W-1:0]   ir;
    logic [DBG_DATA_W-1:0] data;
  } dbg_cmd_t;

endpackage

// File: rtl/dbg_cmd_sysclk_decoder_toggle_sync.sv
// Resynchronises a TCK-domain toggle onto clk and turns each edge of it,
// either polarity, into a single-cycle event.
module dbg_toggle_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tgl_i,
  output logic event_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tgl_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign event_o = sync_q[SYNC_STAGES-1] ^ hist_q;

endmodule

// File: rtl/dbg_cmd_sysclk_decoder.sv
// Debug command decoder, clk side: queues {ir, sr} on every update-DR and
// emits per-channel action / no-action strobes as commands are consumed.
module dbg_cmd_sysclk_decoder
  import dbg_cmd_pkg::*;
#(
  parameter int DATA_W      = DBG_DATA_W,
  parameter int IR_W        = DBG_IR_W,
  parameter int ACT_BIT     = DBG_ACT_BIT,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4,
  localparam int NUM_CH     = 2**IR_W,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sr,
  input  logic [IR_W-1:0]   ir_in,
  input  logic              udr_tgl,
  input  logic              uir_tgl,
  input  logic              cmd_ready,
  input  logic              clr_overflow,
  output logic [DATA_W-1:0] jdo,
  output logic [IR_W-1:0]   cmd_ir,
  output logic              cmd_valid,
  output logic [NUM_CH-1:0] take_action,
  output logic [NUM_CH-1:0] take_no_action,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = IR_W + DATA_W;

  logic udr_ev, uir_ev;

  dbg_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
    .clk_i(clk), .rst_i(reset), .tgl_i(udr_tgl), .event_o(udr_ev)
  );

  dbg_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
    .clk_i(clk), .rst_i(reset), .tgl_i(uir_tgl), .event_o(uir_ev)
  );

  logic [IR_W-1:0]   ir_q;
  logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              overflow_q, overflow_d;
  logic [ENT_W-1:0]  last_q, head;
  logic [NUM_CH-1:0] act_q, act_d, noact_q, noact_d;
  logic              full, pop, push;

  // When empty the outputs show the most recently popped command.
  assign head      = (level_q != '0) ? mem_q[rd_ptr_q] : last_q;
  assign jdo       = head[DATA_W-1:0];
  assign cmd_ir    = head[ENT_W-1 -: IR_W];
  assign cmd_valid = (level_q != '0);
  assign full      = (level_q == LVL_W'(FIFO_DEPTH));
  assign pop       = cmd_valid && cmd_ready;
  assign push      = udr_ev && (!full || pop);

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (pop && !push) begin
      level_d = level_q - LVL_W'(1);
    end

    overflow_d = overflow_q;
    if (clr_overflow) begin
      overflow_d = 1'b0;
    end
    if (udr_ev && full && !pop) begin
      overflow_d = 1'b1;
    end

    act_d   = '0;
    noact_d = '0;
    if (pop) begin
      if (head[ACT_BIT]) begin
        act_d = NUM_CH'(1) << cmd_ir;
      end else begin
        noact_d = NUM_CH'(1) << cmd_ir;
      end
    end
  end

  // Push samples ir_q before a same-cycle update-IR lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      last_q     <= '0;
      act_q      <= '0;
      noact_q    <= '0;
    end else begin
      if (uir_ev) begin
        ir_q <= ir_in;
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        last_q   <= head;
      end
      level_q    <= level_d;
      overflow_q <= overflow_d;
      act_q      <= act_d;
      noact_q    <= noact_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {ir_q, sr};
    end
  end

  assign take_action    = act_q;
  assign take_no_action = noact_q;
  assign fifo_level     = level_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_dbg_cmd_sysclk_decoder.sv
// Scoreboard bench for dbg_cmd_sysclk_decoder: stimulus queues expected
// commands, a negedge monitor checks every pop and the strobe that follows.
module tb_dbg_cmd_sysclk_decoder;

  localparam int DATA_W = 38;
  localparam int IR_W   = 2;
  localparam int NUM_CH = 4;
  localparam int LVL_W  = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] sr;
  logic [IR_W-1:0]   ir_in;
  logic              udr_tgl, uir_tgl, cmd_ready, clr_overflow;
  logic [DATA_W-1:0] jdo;
  logic [IR_W-1:0]   cmd_ir;
  logic              cmd_valid;
  logic [NUM_CH-1:0] take_action, take_no_action;
  logic [LVL_W-1:0]  fifo_level;
  logic              overflow;

  dbg_cmd_sysclk_decoder #(
    .DATA_W(DATA_W), .IR_W(IR_W), .ACT_BIT(34), .SYNC_STAGES(2), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .sr(sr), .ir_in(ir_in),
    .udr_tgl(udr_tgl), .uir_tgl(uir_tgl), .cmd_ready(cmd_ready),
    .clr_overflow(clr_overflow), .jdo(jdo), .cmd_ir(cmd_ir),
    .cmd_valid(cmd_valid), .take_action(take_action),
    .take_no_action(take_no_action), .fifo_level(fifo_level),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IR_W-1:0]   ir;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t            sb[$];
  int              n_pass  = 0;
  int              n_total = 0;
  logic [IR_W-1:0] model_ir = '0;
  logic            pend_v  = 1'b0;
  logic [2*NUM_CH-1:0] pend_s = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  // Monitor: a pop seen at negedge produces a strobe visible at the next negedge.
  always @(negedge clk) begin
    exp_t e;
    logic [NUM_CH-1:0] oh;
    if (reset) begin
      pend_v = 1'b0;
    end else begin
      if (pend_v || take_action != '0 || take_no_action != '0)
        chk("strobe", {take_action, take_no_action}, pend_v ? pend_s : '0);
      pend_v = 1'b0;
      if (cmd_valid && cmd_ready) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL pop_unexpected: got pop of jdo=%h, want no pending command", jdo);
        end else begin
          e = sb.pop_front();
          chk("pop_jdo", jdo, e.data);
          chk("pop_cmd_ir", cmd_ir, e.ir);
          oh = NUM_CH'(1) << e.ir;
          pend_s = e.data[34] ? {oh, 4'b0000} : {4'b0000, oh};
          pend_v = 1'b1;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_ir(input logic [IR_W-1:0] ir);
    ir_in   = ir;
    uir_tgl = ~uir_tgl;
    model_ir = ir;
    tick(5);
  endtask

  task automatic send_dr(input logic [DATA_W-1:0] d, input bit accept);
    exp_t e;
    sr = d;
    if (accept) begin
      e.ir = model_ir;
      e.data = d;
      sb.push_back(e);
    end
    udr_tgl = ~udr_tgl;
    tick(5);
  endtask

  task automatic drain();
    cmd_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (!cmd_valid) break;
      tick(1);
    end
    chk("drain_empty", cmd_valid, 0);
    tick(2);
    cmd_ready = 1'b0;
    chk("sb_empty", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1);
  end

  initial begin
    exp_t e;
    reset = 1'b1; sr = '0; ir_in = '0; udr_tgl = 1'b0; uir_tgl = 1'b0;
    cmd_ready = 1'b0; clr_overflow = 1'b0;
    tick(3);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_jdo", jdo, 0);
    chk("rst_cmd_ir", cmd_ir, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_strobes", {take_action, take_no_action}, 0);
    reset = 1'b0;
    tick(2);

    // Single command: latency and action strobe on channel 2
    send_ir(2'd2);
    sr = 38'h04_0000_1234;
    e.ir = 2'd2; e.data = 38'h04_0000_1234; sb.push_back(e);
    udr_tgl = ~udr_tgl;
    tick(1);
    chk("lat_e0_valid", cmd_valid, 0);
    tick(1);
    chk("lat_e1_valid", cmd_valid, 0);
    tick(1);
    chk("lat_e2_valid", cmd_valid, 1);
    chk("lat_e2_jdo", jdo, 38'h04_0000_1234);
    chk("lat_e2_cmd_ir", cmd_ir, 2);
    tick(2);
    drain();
    chk("hold_jdo_empty", jdo, 38'h04_0000_1234);

    // No-action path on channel 0
    send_ir(2'd0);
    send_dr(38'h00_0000_5678, 1'b1);
    drain();

    // Fill and overflow
    for (int i = 0; i < 5; i++) begin
      send_dr(38'h01_0000_0000 + 38'(i), i < 4);
      if (i == 3) begin
        chk("fill_level4", fifo_level, 4);
        chk("fill_no_ovf", overflow, 0);
      end
    end
    chk("ovf_level", fifo_level, 4);
    chk("ovf_set", overflow, 1);
    chk("ovf_head", jdo, 38'h01_0000_0000);
    clr_overflow = 1'b1;
    tick(1);
    clr_overflow = 1'b0;
    chk("ovf_cleared", overflow, 0);
    drain();

    // Simultaneous update-IR and update-DR
    send_ir(2'd1);
    ir_in = 2'd3;
    sr = 38'h00_0000_AAAA;
    e.ir = 2'd1; e.data = 38'h00_0000_AAAA; sb.push_back(e);
    uir_tgl = ~uir_tgl;
    udr_tgl = ~udr_tgl;
    tick(5);
    model_ir = 2'd3;
    chk("simul_cmd_ir_old", cmd_ir, 1);
    send_dr(38'h04_0000_BBBB, 1'b1);
    drain();

    // Full with pop and push on the same edge, ten commands through wrap-around
    for (int i = 0; i < 4; i++)
      send_dr(38'h00_0000_0100 + 38'(i) + ((i % 2) ? 38'h04_0000_0000 : 38'h0), 1'b1);
    for (int i = 4; i < 10; i++) begin
      sr = 38'h00_0000_0100 + 38'(i) + ((i % 2) ? 38'h04_0000_0000 : 38'h0);
      e.ir = model_ir; e.data = sr; sb.push_back(e);
      udr_tgl = ~udr_tgl;
      tick(2);
      cmd_ready = 1'b1;
      tick(1);
      cmd_ready = 1'b0;
      chk("fullpp_level", fifo_level, 4);
      chk("fullpp_no_ovf", overflow, 0);
      tick(2);
    end
    drain();

    // Asynchronous reset with three commands queued
    for (int i = 0; i < 3; i++) send_dr(38'h04_0000_0F00 + 38'(i), 1'b1);
    chk("mid_level3", fifo_level, 3);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_cmd_valid", cmd_valid, 0);
    chk("arst_level", fifo_level, 0);
    chk("arst_jdo", jdo, 0);
    chk("arst_cmd_ir", cmd_ir, 0);
    chk("arst_overflow", overflow, 0);
    sb.delete();
    udr_tgl = 1'b0;
    uir_tgl = 1'b0;
    tick(2);
    reset = 1'b0;
    cmd_ready = 1'b1;
    tick(10);
    chk("post_rst_valid", cmd_valid, 0);
    chk("post_rst_level", fifo_level, 0);
    cmd_ready = 1'b0;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
